// File: rtl/i2c_slave_read_byte_pkg.sv
// Shared types and constants for the I2C slave byte receiver.
// Optional input synchronizers: I2C_INPUT_SYNC_EN.
package i2c_pkg;

  localparam int   DATA_WIDTH_DEF = 8;
  localparam int   CNT_W_DEF      = $clog2(DATA_WIDTH_DEF);
  localparam logic LINE_RST       = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/i2c_slave_read_byte_if.sv
// Controller-facing bundle of the I2C slave byte receiver.
// Carries enable, line levels and the received byte/status.
interface i2c_slave_read_byte_if
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                  byte_read_en;
  logic [DATA_WIDTH-1:0] byte_read_o;
  logic                  byte_read_finish;
  logic                  byte_read_abort;
  logic                  scl_i;
  logic                  sda_i;

  modport master (
    output byte_read_en,
    output scl_i,
    output sda_i,
    input  byte_read_o,
    input  byte_read_finish,
    input  byte_read_abort
  );

  modport slave (
    input  byte_read_en,
    input  scl_i,
    input  sda_i,
    output byte_read_o,
    output byte_read_finish,
    output byte_read_abort
  );

endinterface

// File: rtl/i2c_slave_read_bit.sv
// SCL rise and START/STOP detection from registered line levels.
// I2C_INPUT_SYNC_EN adds a 2-flop synchronizer on each line.
module i2c_slave_read_bit
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic bit_read_o,
  output logic bit_read_valid,
  output logic bus_cond_o
);

  logic scl_c;
  logic sda_c;
  logic scl_last_q;
  logic sda_last_q;

`ifdef I2C_INPUT_SYNC_EN
  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= {2{LINE_RST}};
      sda_sync_q <= {2{LINE_RST}};
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

  assign scl_c = scl_sync_q[1];
  assign sda_c = sda_sync_q[1];
`else
  assign scl_c = scl_i;
  assign sda_c = sda_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_last_q <= LINE_RST;
      sda_last_q <= LINE_RST;
    end else begin
      scl_last_q <= scl_c;
      sda_last_q <= sda_c;
    end
  end

  // SDA moving while SCL stays high is a START or STOP
  assign bit_read_o     = sda_c;
  assign bit_read_valid = ~scl_last_q & scl_c;
  assign bus_cond_o     = scl_last_q & scl_c
                        & (sda_last_q ^ sda_c);

endmodule

// File: rtl/i2c_slave_read_byte.sv
// Slave-side I2C byte receiver: MSB-first shift on SCL rise.
// Build option I2C_INPUT_SYNC_EN synchronizes scl/sda first.
module i2c_slave_read_byte
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  i2c_slave_read_byte_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  logic bit_val;
  logic bit_valid;
  logic bus_cond;

  i2c_slave_read_bit u_bit (
    .clk            (clk),
    .rst            (rst),
    .scl_i          (bus.scl_i),
    .sda_i          (bus.sda_i),
    .bit_read_o     (bit_val),
    .bit_read_valid (bit_valid),
    .bus_cond_o     (bus_cond)
  );

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] byte_q, byte_d;
  logic                  fin_q, fin_d;
  logic                  abort_q, abort_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      fin_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      fin_q   <= fin_d;
      abort_q <= abort_d;
    end
  end

  // finish/byte register on the last rise, so they show during DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    fin_d   = 1'b0;
    abort_d = 1'b0;
    if (!bus.byte_read_en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = RECV;
        end
        RECV: begin
          if (bit_valid) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], bit_val};
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = DONE;
              fin_d   = 1'b1;
              byte_d  = shift_d;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (bus_cond) begin
            abort_d = 1'b1;
            cnt_d   = '0;
          end
        end
        DONE: begin
          cnt_d   = '0;
          state_d = RECV;
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.byte_read_o      = byte_q;
  assign bus.byte_read_finish = fin_q;
  assign bus.byte_read_abort  = abort_q;

endmodule

// File: tb/tb_i2c_slave_read_byte.sv
// Randomized bench for i2c_slave_read_byte against a bit-stream model.
// Model: per-rise bit list, 8 bits -> byte event, START/STOP -> abort.
module tb_i2c_slave_read_byte;
  import i2c_pkg::*;

`ifdef I2C_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_slave_read_byte_if #(.DATA_WIDTH(8)) bus ();

  i2c_slave_read_byte #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs   = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               tag, got, exp, cyc);
    end
  endtask

  logic [7:0] exp_fin[int];
  bit         exp_ab[int];
  logic [7:0] byte_set[int];
  logic [7:0] m_byte = 8'h00;
  logic [7:0] acc    = 8'h00;
  int         nb     = 0;
  bit         mon_on = 1'b0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (byte_set.exists(cyc)) m_byte = byte_set[cyc];
      if (exp_fin.exists(cyc)) m_byte = exp_fin[cyc];
      check("finish", 32'(bus.byte_read_finish),
            32'(exp_fin.exists(cyc)));
      check("abort", 32'(bus.byte_read_abort),
            32'(exp_ab.exists(cyc)));
      check("byte_o", 32'(bus.byte_read_o), 32'(m_byte));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic raise_scl();
    bus.scl_i = 1'b1;
    if (bus.byte_read_en) begin
      acc = {acc[6:0], bus.sda_i};
      nb++;
      if (nb == 8) begin
        exp_fin[cyc + 1 + LAT] = acc;
        nb = 0;
      end
    end
  endtask

  task automatic send_bit(input logic b);
    tick($urandom_range(1, 3));
    bus.sda_i = b;
    tick($urandom_range(1, 3));
    raise_scl();
    tick($urandom_range(2, 4));
    bus.scl_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
  endtask

  // start=1: SDA high->low under SCL high; else low->high (STOP)
  task automatic bus_event(input bit start);
    tick(2);
    bus.sda_i = start;
    tick(2);
    raise_scl();
    tick(2);
    bus.sda_i = ~bus.sda_i;
    if (bus.byte_read_en) begin
      exp_ab[cyc + 1 + LAT] = 1'b1;
      nb = 0;
    end
    tick(2);
    bus.scl_i = 1'b0;
    tick(1);
  endtask

  task automatic enable();
    bus.byte_read_en = 1'b1;
    tick(2);
  endtask

  task automatic disable_rx();
    tick(1);
    bus.byte_read_en = 1'b0;
    nb = 0;
    tick(4);
  endtask

  task automatic pulse_reset();
    tick(2);
    rst = 1'b1;
    byte_set[cyc + 1] = 8'h00;
    nb = 0;
    tick(1);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    bus.byte_read_en = 1'b0;
    bus.scl_i        = 1'b1;
    bus.sda_i        = 1'b1;
    tick(2);
    mon_on = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    bus.scl_i = 1'b0;
    tick(4);

    enable();
    send_byte(8'hA5);
    tick(6);

    send_byte(8'h3C);
    send_byte(8'hFF);
    tick(6);

    send_bits(3);
    bus_event(1'b1);
    send_byte(8'h81);
    tick(6);

    send_bits(5);
    disable_rx();
    enable();
    send_byte(8'h5A);
    tick(6);

    send_bits(6);
    pulse_reset();
    send_byte(8'h12);
    tick(6);

    bus_event(1'b1);
    send_byte(8'hC3);
    disable_rx();
    bus_event(1'b0);
    bus_event(1'b1);
    enable();

    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 4))
        0, 1: send_byte(8'($urandom));
        2: begin
          send_bits($urandom_range(0, 7));
          bus_event(1'($urandom_range(0, 1)));
        end
        3: begin
          send_bits($urandom_range(0, 7));
          disable_rx();
          enable();
        end
        default: begin
          send_bits($urandom_range(0, 7));
          pulse_reset();
        end
      endcase
    end
    tick(10);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
